// File: rtl/vga_sync_if.sv
// Raster timing bundle from vga_sync: pixel/line coordinates, sync strobes and pacing pulses.
interface vga_sync_if;
    logic [9:0] hc;
    logic [9:0] vc;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       pix_tick;
    logic       frame_start;

    modport master (
        output hc, vc, hsync, vsync, video_on, pix_tick, frame_start
    );

    modport slave (
        input hc, vc, hsync, vsync, video_on, pix_tick, frame_start
    );
endinterface

// File: rtl/vga_sync.sv
// VGA raster generator: pixel-clock divider, h/v counters with phase FSMs, and
// zero-skew registered sync/blanking derived from the next counter values.
module vga_sync #(
    parameter int CLK_DIV = 4,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SW    = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SW    = 2,
    parameter int V_BP    = 33
) (
    input  logic       clk,
    input  logic       rst,
    vga_sync_if.master vga
);

    localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {VIS, FP, SYNC, BP} state_t;

    logic [DW-1:0] div;
    logic          tick;
    logic          h_wrap;
    logic          v_wrap;
    logic [9:0]    hc_nxt;
    logic [9:0]    vc_nxt;
    state_t        h_state, h_state_nxt;
    state_t        v_state, v_state_nxt;

    assign tick   = (div == DIV_LAST);
    assign h_wrap = tick && (vga.hc == 10'(H_TOT - 1));
    assign v_wrap = h_wrap && (vga.vc == 10'(V_TOT - 1));

    always_comb begin
        hc_nxt = vga.hc;
        vc_nxt = vga.vc;
        if (tick)
            hc_nxt = h_wrap ? 10'd0 : vga.hc + 10'd1;
        if (h_wrap)
            vc_nxt = v_wrap ? 10'd0 : vga.vc + 10'd1;
    end

    // Phases advance on the last count of each region so they line up with hc_nxt.
    always_comb begin
        h_state_nxt = h_state;
        if (tick) begin
            case (h_state)
                VIS:  if (vga.hc == 10'(H_VIS - 1))               h_state_nxt = FP;
                FP:   if (vga.hc == 10'(H_VIS + H_FP - 1))        h_state_nxt = SYNC;
                SYNC: if (vga.hc == 10'(H_VIS + H_FP + H_SW - 1)) h_state_nxt = BP;
                BP:   if (h_wrap)                                 h_state_nxt = VIS;
                default:                                          h_state_nxt = VIS;
            endcase
        end
    end

    always_comb begin
        v_state_nxt = v_state;
        if (h_wrap) begin
            case (v_state)
                VIS:  if (vga.vc == 10'(V_VIS - 1))               v_state_nxt = FP;
                FP:   if (vga.vc == 10'(V_VIS + V_FP - 1))        v_state_nxt = SYNC;
                SYNC: if (vga.vc == 10'(V_VIS + V_FP + V_SW - 1)) v_state_nxt = BP;
                BP:   if (v_wrap)                                 v_state_nxt = VIS;
                default:                                          v_state_nxt = VIS;
            endcase
        end
    end

    // NOTE: every register here, including the FSM state, is written with <= so all
    // outputs of one edge see the same pre-edge values; the asynchronous reset forces
    // the visible position to 0,0 with both syncs inactive.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div             <= '0;
            h_state         <= VIS;
            v_state         <= VIS;
            vga.hc          <= '0;
            vga.vc          <= '0;
            vga.hsync       <= 1'b1;
            vga.vsync       <= 1'b1;
            vga.video_on    <= 1'b1;
            vga.pix_tick    <= 1'b0;
            vga.frame_start <= 1'b0;
        end else begin
            div             <= tick ? '0 : div + DW'(1);
            h_state         <= h_state_nxt;
            v_state         <= v_state_nxt;
            vga.hc          <= hc_nxt;
            vga.vc          <= vc_nxt;
            vga.hsync       <= (h_state_nxt != SYNC);
            vga.vsync       <= (v_state_nxt != SYNC);
            vga.video_on    <= (h_state_nxt == VIS) && (v_state_nxt == VIS);
            vga.pix_tick    <= tick;
            vga.frame_start <= v_wrap;
        end
    end

endmodule

// File: doc/vga_sync.md
VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, meaning system clocks per pixel (100 MHz to 25 MHz).
REQ-002 The block SHALL have parameter H_VIS, default 640, meaning visible pixels per line.
REQ-003 The block SHALL have parameter H_FP / H_SW / H_BP, defaults 16 / 96 / 48, meaning horizontal front porch, sync width and back porch in pixels.
REQ-004 The block SHALL have parameter V_VIS, default 480, meaning visible lines per frame.
REQ-005 The block SHALL have parameter V_FP / V_SW / V_BP, defaults 10 / 2 / 33, meaning vertical front porch, sync width and back porch in lines.
REQ-006 The block SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port hc, output, 10 bits: current horizontal pixel coordinate, registered.
REQ-009 The block SHALL have port vc, output, 10 bits: current vertical line coordinate, registered.
REQ-010 The block SHALL have port hsync, output, 1 bit: horizontal sync, active-low, registered.
REQ-011 The block SHALL have port vsync, output, 1 bit: vertical sync, active-low, registered.
REQ-012 The block SHALL have port video_on, output, 1 bit: high when hc < H_VIS and vc < V_VIS, registered.
REQ-013 The block SHALL have port pix_tick, output, 1 bit: one-clk pulse marking each pixel period.
REQ-014 The block SHALL have port frame_start, output, 1 bit: one-clk pulse coincident with the pix_tick on which hc and vc become 0,0.

Function
REQ-015 Horizontal total H_TOT SHALL be H_VIS+H_FP+H_SW+H_BP (800) and vertical total V_TOT SHALL be V_VIS+V_FP+V_SW+V_BP (525).
REQ-016 A divider counter SHALL count 0..CLK_DIV-1 on every clk and wrap to 0.
REQ-017 pix_tick SHALL be high for exactly the one clk in which the divider counter equals CLK_DIV-1.
REQ-018 hc SHALL increment by 1 only on clocks with pix_tick high.
REQ-019 hc SHALL wrap from H_TOT-1 (799) to 0 on a pix_tick.
REQ-020 vc SHALL increment by 1 only on the pix_tick where hc wraps.
REQ-021 vc SHALL wrap from V_TOT-1 (524) to 0 when hc also wraps.
REQ-022 hc and vc SHALL never take values of H_TOT or V_TOT or above.
REQ-023 hsync, vsync and video_on SHALL be computed from the next values of hc/vc and registered, so that they are cycle-aligned with the hc/vc they describe (zero skew).
REQ-024 hsync SHALL be 0 when H_VIS+H_FP <= hc < H_VIS+H_FP+H_SW (656..751) and 1 otherwise.
REQ-025 vsync SHALL be 0 when V_VIS+V_FP <= vc < V_VIS+V_FP+V_SW (490..491) and 1 otherwise.
REQ-026 The horizontal position SHALL be tracked as a four-state FSM — VIS, FP, SYNC, BP — advancing on pix_tick at hc = 639, 655, 751 and 799, with BP returning to VIS.
REQ-027 The vertical position SHALL be tracked as a four-state FSM with the same state names, advancing on line wrap at vc = 479, 489, 491 and 524.
REQ-028 The FSM state SHALL be consistent with the counter values at every clk; the verification bench checks this with an assertion.
REQ-029 frame_start SHALL pulse once per V_TOT*H_TOT pix_ticks (420000), on the tick where hc and vc both wrap to 0.
REQ-030 With CLK_DIV = 1, pix_tick SHALL be constantly high and the counters SHALL advance every clk.

Reset
REQ-031 While rst = 0, the block SHALL asynchronously force: divider = 0, hc = 0, vc = 0, both FSMs = VIS, hsync = 1, vsync = 1, video_on = 1, pix_tick = 0, frame_start = 0.
REQ-032 The first pix_tick SHALL occur CLK_DIV clks after rst deasserts.
REQ-033 On that first pix_tick, hc SHALL become 1; frame_start SHALL NOT pulse for the reset-originated 0,0 position.
REQ-034 Reset asserted mid-line or mid-sync SHALL take effect immediately, without waiting for a clk edge, and SHALL drive hsync and vsync inactive (1).

Verification
REQ-035 Release reset with CLK_DIV = 4 -> pix_tick first high at clk 4; thereafter period 4; hc = 1 after the first tick.
REQ-036 Run one full line -> hsync = 0 for exactly 96 ticks starting at hc = 656; video_on = 0 from hc = 640 through 799; hc returns to 0 and vc = 1.
REQ-037 Run one full frame -> vsync = 0 only during vc = 490..491 (1600 ticks); frame_start occurs exactly once, 420000 ticks after the first 0,0 wrap.
REQ-038 Corner wrap at hc = 799, vc = 524 -> on the next tick hc = 0, vc = 0, frame_start = 1, video_on = 1, hsync = 1, vsync = 1.
REQ-039 Assert rst = 0 asynchronously (mid-clk) while hc = 700 and hsync = 0 -> outputs reach their reset values before the next clk edge; after release the sequence restarts per REQ-032.
REQ-040 Set CLK_DIV = 1 -> pix_tick is constantly 1; a line takes 800 clks and a frame takes 420000 clks.
